// File: rtl/wb_buf_manager.sv
// rtl/wb_buf_manager.sv - Wishbone triple-buffer manager for LED frame storage
module wb_buf_manager #(
   parameter int          ADDR_WIDTH = 32,
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] BUF_BASE   = 32'h0000_1000,
   parameter logic [31:0] BUF_SIZE   = 32'h0000_0400
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] bmgr_wbs_address,
   input  logic [DATA_WIDTH-1:0] bmgr_wbs_writedata,
   output logic [DATA_WIDTH-1:0] bmgr_wbs_readdata,
   input  logic                  bmgr_wbs_strobe,
   input  logic                  bmgr_wbs_cycle,
   input  logic                  bmgr_wbs_write,
   output logic                  bmgr_wbs_ack
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ACK       = 2'd1,
      S_WAIT_DROP = 2'd2
   } state_t;

   localparam logic [1:0] REG_ACQ_WR = 2'd0;
   localparam logic [1:0] REG_REL_WR = 2'd1;
   localparam logic [1:0] REG_ACQ_RD = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              wr_idx_q, wr_idx_d;
   logic                    wr_vld_q, wr_vld_d;
   logic [1:0]              rdy_idx_q, rdy_idx_d;
   logic                    rdy_vld_q, rdy_vld_d;
   logic [1:0]              rd_idx_q, rd_idx_d;
   logic                    rd_vld_q, rd_vld_d;
   logic [15:0]             frames_q, frames_d;
   logic [7:0]              dropped_q, dropped_d;

   logic                    req;
   logic                    fire;
   logic [1:0]              reg_sel;
   logic [3:0]              used;
   logic [1:0]              free_idx;
   logic                    unused_bits;

   assign req         = bmgr_wbs_cycle & bmgr_wbs_strobe;
   assign fire        = (state_q == S_IDLE) && req;
   assign reg_sel     = bmgr_wbs_address[3:2];
   assign unused_bits = ^{bmgr_wbs_address[ADDR_WIDTH-1:4], bmgr_wbs_address[1:0],
                          bmgr_wbs_writedata};

   function automatic logic [DATA_WIDTH-1:0] buf_addr(input logic [1:0] idx);
      return DATA_WIDTH'(BUF_BASE) + DATA_WIDTH'(idx) * DATA_WIDTH'(BUF_SIZE);
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         rdata_q   <= '0;
         wr_idx_q  <= 2'd0;
         wr_vld_q  <= 1'b0;
         rdy_idx_q <= 2'd0;
         rdy_vld_q <= 1'b0;
         rd_idx_q  <= 2'd0;
         rd_vld_q  <= 1'b0;
         frames_q  <= 16'd0;
         dropped_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         rdata_q   <= rdata_d;
         wr_idx_q  <= wr_idx_d;
         wr_vld_q  <= wr_vld_d;
         rdy_idx_q <= rdy_idx_d;
         rdy_vld_q <= rdy_vld_d;
         rd_idx_q  <= rd_idx_d;
         rd_vld_q  <= rd_vld_d;
         frames_q  <= frames_d;
         dropped_q <= dropped_d;
      end
   end

   // One ack per strobe: a held strobe parks in WAIT_DROP until released.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (req) state_d = S_ACK;
         S_ACK:       state_d = S_WAIT_DROP;
         S_WAIT_DROP: if (!req) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   always_comb begin
      used = 4'b0000;
      if (wr_vld_q)  used[wr_idx_q]  = 1'b1;
      if (rdy_vld_q) used[rdy_idx_q] = 1'b1;
      if (rd_vld_q)  used[rd_idx_q]  = 1'b1;
      if (!used[0])      free_idx = 2'd0;
      else if (!used[1]) free_idx = 2'd1;
      else               free_idx = 2'd2;
   end

   // Slot updates and the read value are computed once, on the IDLE->ACK edge.
   always_comb begin
      rdata_d   = '0;
      wr_idx_d  = wr_idx_q;
      wr_vld_d  = wr_vld_q;
      rdy_idx_d = rdy_idx_q;
      rdy_vld_d = rdy_vld_q;
      rd_idx_d  = rd_idx_q;
      rd_vld_d  = rd_vld_q;
      frames_d  = frames_q;
      dropped_d = dropped_q;
      if (fire) begin
         case (reg_sel)
            REG_ACQ_WR: begin
               if (!bmgr_wbs_write) begin
                  if (wr_vld_q) begin
                     rdata_d = buf_addr(wr_idx_q);
                  end else begin
                     wr_idx_d = free_idx;
                     wr_vld_d = 1'b1;
                     rdata_d  = buf_addr(free_idx);
                  end
               end
            end
            REG_REL_WR: begin
               if (bmgr_wbs_write && wr_vld_q) begin
                  if (rdy_vld_q && (dropped_q != 8'hFF)) dropped_d = dropped_q + 8'd1;
                  rdy_idx_d = wr_idx_q;
                  rdy_vld_d = 1'b1;
                  wr_vld_d  = 1'b0;
                  frames_d  = frames_q + 16'd1;
               end
            end
            REG_ACQ_RD: begin
               if (!bmgr_wbs_write) begin
                  if (rdy_vld_q) begin
                     rd_idx_d  = rdy_idx_q;
                     rd_vld_d  = 1'b1;
                     rdy_vld_d = 1'b0;
                     rdata_d   = buf_addr(rdy_idx_q);
                  end else if (rd_vld_q) begin
                     rdata_d = buf_addr(rd_idx_q);
                  end else begin
                     rdata_d = '1;
                  end
               end
            end
            REG_STATUS: begin
               if (!bmgr_wbs_write)
                  rdata_d = DATA_WIDTH'({5'b0, rd_vld_q, rdy_vld_q, wr_vld_q, dropped_q, frames_q});
            end
            default: rdata_d = '0;
         endcase
      end
   end

   always_comb begin
      bmgr_wbs_ack      = (state_q == S_ACK);
      bmgr_wbs_readdata = bmgr_wbs_ack ? rdata_q : '0;
   end

endmodule

// File: doc/wb_buf_manager.md
Name: wb_buf_manager

Overview:
- Wishbone slave behind the NIC's bmgr port at BUF_MANAGER_BASE_ADDR; arbitrates triple-buffered LED frame storage in memory.
- Buffer updater (bupd) acquires a free buffer and releases it when filled; LED driver (ldrv) acquires the newest ready frame.
- Returns buffer base addresses that masters then use on the mem port.
- Keeps frame/drop counters for the controller (ctrl).

Parameters:
- ADDR_WIDTH, 32, Wishbone address width
- DATA_WIDTH, 32, Wishbone data width (>=32)
- BUF_BASE, 32'h0000_1000, memory address of buffer 0
- BUF_SIZE, 32'h0000_0400, byte stride between buffers

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- bmgr_wbs_address  in  ADDR_WIDTH  byte address; only bits [3:2] decoded
- bmgr_wbs_writedata  in  DATA_WIDTH  write data (ignored except REL_WR)
- bmgr_wbs_readdata  out  DATA_WIDTH  read data, valid while ack=1
- bmgr_wbs_strobe  in  1  Wishbone STB
- bmgr_wbs_cycle  in  1  Wishbone CYC
- bmgr_wbs_write  in  1  1=write, 0=read
- bmgr_wbs_ack  out  1  single-cycle acknowledge

Behaviour:
- Reset (reset=0 at posedge): ack=0, readdata=0, FSM=IDLE, wr/rdy/rd slots invalid, frames=0, dropped=0. Applies mid-transaction; pending request is dropped, no ack.
- Bus FSM: IDLE -> ACK when cycle&strobe (sample cycle N, ack=1 in cycle N+1, one cycle only). ACK -> WAIT_DROP. WAIT_DROP -> IDLE when ~(cycle&strobe). One ack per STB assertion; held STB never re-fires.
- Side effects commit on the IDLE->ACK edge, exactly once per transaction.
- Slots: wr_idx, rdy_idx, rd_idx (2 bits each, plus valid flag). Valid indices always distinct.
- Free buffer = lowest index in {0,1,2} not held by a valid slot. Address(i) = BUF_BASE + i*BUF_SIZE, truncated to DATA_WIDTH. INVALID = all ones.
- 0x0 ACQ_WR (read): if wr valid, return addr(wr_idx), no change. Else take lowest free buffer into wr, return its address. Never fails with 3 buffers.
- 0x4 REL_WR (write): if wr invalid, no-op (acked). Else:
  - if rdy valid, old rdy becomes free and dropped++ (8-bit, saturates at 255);
  - rdy <= wr, wr invalid, frames++ (16-bit, wraps 0xFFFF->0).
- 0x8 ACQ_RD (read):
  - if rdy valid: old rd becomes free, rd <= rdy, rdy invalid, return addr(new rd);
  - else if rd valid: return addr(rd_idx) (repeat frame);
  - else return INVALID.
- 0xC STATUS (read, writes ignored): [15:0] frames, [23:16] dropped, [24] wr valid, [25] rdy valid, [26] rd valid, rest 0.
- Write to 0x0/0x8/0xC, or read of 0x4: acked, readdata=0, no state change.
- readdata is 0 whenever ack=0.
- cycle without strobe, or strobe without cycle: ignored.

Test Plan:
- Reset then read 0x8 -> ack one cycle after STB, readdata=32'hFFFF_FFFF; read 0xC -> 0.
- Read 0x0 -> 32'h0000_1000; read 0x0 again -> 32'h0000_1000; write 0x4; read 0x8 -> 32'h0000_1000; STATUS = 32'h0400_0001.
- ACQ_WR/REL_WR twice with no ACQ_RD -> second ACQ_WR returns 32'h0000_1400; STATUS[23:16]=1, [15:0]=2, [25]=1; then ACQ_RD returns 32'h0000_1400.
- With rd=buf0, ACQ_WR returns 32'h0000_1400 (buf1), release, ACQ_WR -> 32'h0000_1800 (buf2); release, then ACQ_RD -> 32'h0000_1800 and buf0/buf1 free; next ACQ_WR -> 32'h0000_1000.
- Master holds STB 5 cycles -> exactly one ack, counter +1 on REL_WR; STB drop/re-raise -> second ack.
- reset=0 in cycle after STB sampled -> no ack, STATUS=0 after reset; 300 REL_WR cycles without reads -> dropped=255 (saturated), frames=300.
